blue_motion: RTL

- Position/physics controller for the blue player sprite. Produces x_blue/y_blue, which the slime-freeze detector and the renderer consume.
- Consumes that detector's frozen flag: while frozen, the sprite is locked in place.
- Implements horizontal walking, a fixed-arc jump with integer gravity, and floor landing, all stepped on an internal game tick.

---
 rtl/game_pkg.sv | 16 +
 rtl/tick_gen.sv | 28 ++
 rtl/blue_motion.sv | 116 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: player state encoding, screen and sprite sizes.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_FROZ = 2'd3
    } motion_state_t;

    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int BLUE_W = 24;
    localparam int BLUE_H = 41;

endpackage

// File: rtl/tick_gen.sv
// Game tick generator: a one-cycle pulse every TICK_DIV clock cycles.
// Shared by the player motion, the slime patrol and the unfreeze timer.
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [19:0] LAST = 20'(TICK_DIV - 1);

    logic [19:0] count;

    // Free-running divider counting 0..TICK_DIV-1, restarting from 0 on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 20'd1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/blue_motion.sv
// Blue player position and physics: walking, fixed-arc jump with integer
// gravity, floor landing, and a lock-in-place mode while frozen by a slime.
module blue_motion
    import game_pkg::*;
#(
    parameter int         TICK_DIV = 1000000,
    parameter logic [9:0] X_INIT   = 10'd40,
    parameter logic [9:0] X_MAX    = 10'd616,
    parameter logic [8:0] FLOOR_Y  = 9'd400,
    parameter logic [9:0] STEP_X   = 10'd2,
    parameter logic [4:0] JUMP_V   = 5'd12,
    parameter logic [4:0] V_MAX    = 5'd12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic       frozen,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic       airborne,
    output logic [1:0] state_o
);

    motion_state_t state;
    logic [4:0]    vy;
    logic          tick;
    logic [10:0]   x_right;
    logic [9:0]    x_next;
    logic [9:0]    y_fall_sum;
    logic [4:0]    vy_inc;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign x_right    = {1'b0, x_blue} + {1'b0, STEP_X};
    assign y_fall_sum = {1'b0, y_blue} + {5'd0, vy};
    assign vy_inc     = (vy >= V_MAX) ? V_MAX : vy + 5'd1;

    // Next horizontal position, clamped to the screen edges; opposing keys cancel
    always_comb begin
        x_next = x_blue;
        if (key_left && !key_right) begin
            x_next = (x_blue < STEP_X) ? 10'd0 : x_blue - STEP_X;
        end else if (key_right && !key_left) begin
            x_next = (x_right > {1'b0, X_MAX}) ? X_MAX : x_right[9:0];
        end
    end

    // Motion FSM: freeze overrides everything, thaw is immediate, physics steps on ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x_blue   <= X_INIT;
            y_blue   <= FLOOR_Y;
            vy       <= 5'd0;
            airborne <= 1'b0;
        end else if (frozen) begin
            state    <= ST_FROZ;
            airborne <= 1'b0;
        end else if (state == ST_FROZ) begin
            if (y_blue == FLOOR_Y) begin
                state    <= ST_IDLE;
                airborne <= 1'b0;
            end else begin
                state    <= ST_FALL;
                vy       <= 5'd0;
                airborne <= 1'b1;
            end
        end else if (tick) begin
            x_blue <= x_next;
            case (state)
                ST_IDLE: begin
                    if (key_jump) begin
                        state    <= ST_RISE;
                        vy       <= JUMP_V;
                        airborne <= 1'b1;
                    end
                end
                ST_RISE: begin
                    if (y_blue < {4'd0, vy}) begin
                        y_blue <= 9'd0;
                        vy     <= 5'd0;
                        state  <= ST_FALL;
                    end else begin
                        y_blue <= y_blue - {4'd0, vy};
                        vy     <= vy - 5'd1;
                        if (vy == 5'd1) begin
                            state <= ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (y_fall_sum >= {1'b0, FLOOR_Y}) begin
                        y_blue   <= FLOOR_Y;
                        vy       <= 5'd0;
                        state    <= ST_IDLE;
                        airborne <= 1'b0;
                    end else begin
                        y_blue <= y_fall_sum[8:0];
                        vy     <= vy_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = state;

endmodule
